inventory_ctrl: RTL and testbench
=================================

Name: inventory_ctrl

Overview:
- Transaction sequencer in front of the inventory `memory` block (per-code quantity store, combinational read, write-enable `set`).
- Accepts one add, remove, query or clear command at a time over a valid/ready handshake.
- Performs the read-modify-write on the addressed entry: saturating add, floor/reject remove.
- Returns the resulting quantity and a status code; replaces ad-hoc edge-triggered sequencing with a single clocked controller.

Parameters:
- AW, 8, width of item code / memory address.
- DW, 8, width of quantity / memory data.
- STRICT_REMOVE, 0, 1 = reject a remove larger than stock (no write); 0 = clamp the entry to zero.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  0=ADD, 1=REMOVE, 2=QUERY, 3=CLEAR.
- cmd_code  in  AW  item code (memory address).
- cmd_quant  in  DW  quantity operand (ignored for QUERY/CLEAR).
- mem_set  out  1  memory write enable.
- mem_address  out  AW  memory address.
- mem_value  out  DW  memory write data.
- mem_out  in  DW  memory read data, combinational from mem_address.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_qty  out  DW  entry quantity after the command.
- rsp_status  out  2  0=OK, 1=SAT (add saturated), 2=UNDER (remove exceeded stock), 3=reserved.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE -> READ -> WRITE -> RESP -> IDLE. Fixed 4 cycles per command; throughput one command per 4 cycles.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch op/code/quant and go to READ.
  - cmd_valid without ready is ignored; the command is not sampled.
- READ:
  - mem_address=latched code.
  - Capture mem_out into the stock register at the end of the cycle; go to WRITE.
- WRITE:
  - Compute new/status from stock and quant.
  - mem_value=new; mem_set=1 for exactly this cycle unless the op is QUERY or a rejected REMOVE.
  - Go to RESP.
- RESP:
  - rsp_valid=1 for one cycle, with rsp_qty=value now in memory (new, or stock if no write) and rsp_status.
  - Go to IDLE.
- cmd_ready=0 in READ/WRITE/RESP.
- mem_address holds the latched code from READ through RESP; it is 0 in IDLE.
- Latency: command accepted at edge T; write edge T+2; rsp_valid high in cycle after T+2; cmd_ready high again at T+3.
- ADD: sum computed in DW+1 bits. If sum[DW]=1, new=all-ones and status=SAT; else new=sum[DW-1:0] and status=OK.
- REMOVE, quant<=stock: new=stock-quant, status=OK; quant==stock gives 0 and OK.
- REMOVE, quant>stock: status=UNDER.
  - STRICT_REMOVE=1: no write, rsp_qty=stock.
  - STRICT_REMOVE=0: new=0, write performed.
- QUERY: no write; rsp_qty=stock; status=OK.
- CLEAR: new=0; status=OK.
- Reset:
  - On any edge with rst=1: state=IDLE; cmd_ready=0 that cycle; mem_set, mem_address, mem_value, rsp_valid, rsp_qty, rsp_status, busy all 0; latched registers 0.
  - mem_set is gated by !rst, so a reset in the WRITE cycle performs no write.
  - Reset mid-command aborts it with no response.
- A command presented in the first cycle after reset release is accepted (cmd_ready=1).

Decomposition:
- Shared package inv_pkg:
  - op_t enum (ADD/REMOVE/QUERY/CLEAR).
  - status_t enum (OK/SAT/UNDER).
  - ctrl_state_t enum (IDLE/READ/WRITE/RESP).
- One combinational sub-module inv_alu (stock, quant, op, STRICT_REMOVE -> new, status, write_en). Testable standalone.

Test Plan:
- Reset, then ADD code=5 quant=10 on empty memory -> mem_set for one cycle with address 5, value 10; rsp_qty=10, status OK; rsp_valid 3 cycles after accept.
- Entry 5=250, ADD quant=10 -> value 255, status SAT; ADD quant=5 on 250 -> 255, status OK (exact boundary).
- Entry 7=20, REMOVE 20 -> 0, OK. REMOVE 30 with STRICT_REMOVE=0 -> 0, UNDER, write. Same with STRICT_REMOVE=1 -> no mem_set, rsp_qty=20, UNDER.
- QUERY code=5 -> mem_set never high; rsp_qty=current value. CLEAR code=5 -> write 0, OK.
- Back-to-back cmd_valid held high with 3 commands -> each accepted 4 cycles apart; cmd_ready low while busy; responses in order.
- Assert rst in WRITE cycle of an ADD -> no mem_set, no rsp_valid, memory unchanged; next command completes normally.

Source files
------------

// File: rtl/inv_pkg.sv
// Shared types for the inventory transaction sequencer: command opcodes,
// response status codes and controller states.
package inv_pkg;

    typedef enum logic [1:0] {
        OP_ADD    = 2'd0,
        OP_REMOVE = 2'd1,
        OP_QUERY  = 2'd2,
        OP_CLEAR  = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        ST_OK    = 2'd0,
        ST_SAT   = 2'd1,
        ST_UNDER = 2'd2,
        ST_RSVD  = 2'd3
    } status_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/inventory_ctrl_if.sv
// Command, memory-port and response bundle of the inventory controller.
// The slave side is the controller; the master side is the requester plus memory.
interface inventory_ctrl_if
    import inv_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 8
) ();

    logic          cmd_valid;
    logic          cmd_ready;
    op_t           cmd_op;
    logic [AW-1:0] cmd_code;
    logic [DW-1:0] cmd_quant;

    logic          mem_set;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_value;
    logic [DW-1:0] mem_out;

    logic          rsp_valid;
    logic [DW-1:0] rsp_qty;
    status_t       rsp_status;
    logic          busy;

    modport master (
        output cmd_valid, cmd_op, cmd_code, cmd_quant, mem_out,
        input  cmd_ready, mem_set, mem_address, mem_value,
               rsp_valid, rsp_qty, rsp_status, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_code, cmd_quant, mem_out,
        output cmd_ready, mem_set, mem_address, mem_value,
               rsp_valid, rsp_qty, rsp_status, busy
    );

endinterface

// File: rtl/inv_alu.sv
// Combinational quantity update: saturating add, floor/reject remove,
// query and clear. new_qty equals stock whenever no write is requested.
module inv_alu
    import inv_pkg::*;
#(
    parameter int DW            = 8,
    parameter int STRICT_REMOVE = 0
) (
    input  logic [DW-1:0] stock,
    input  logic [DW-1:0] quant,
    input  op_t           op,
    output logic [DW-1:0] new_qty,
    output status_t       status,
    output logic          write_en
);

    logic [DW:0] sum;

    assign sum = {1'b0, stock} + {1'b0, quant};

    always_comb begin
        new_qty  = stock;
        status   = ST_OK;
        write_en = 1'b0;
        case (op)
            OP_ADD: begin
                write_en = 1'b1;
                if (sum[DW]) begin
                    new_qty = '1;
                    status  = ST_SAT;
                end else begin
                    new_qty = sum[DW-1:0];
                end
            end
            OP_REMOVE: begin
                if (quant <= stock) begin
                    new_qty  = stock - quant;
                    write_en = 1'b1;
                end else begin
                    status = ST_UNDER;
                    // lenient mode floors the entry; strict mode leaves it untouched
                    if (STRICT_REMOVE == 0) begin
                        new_qty  = '0;
                        write_en = 1'b1;
                    end
                end
            end
            OP_CLEAR: begin
                new_qty  = '0;
                write_en = 1'b1;
            end
            default: begin
                new_qty  = stock;
                write_en = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/inventory_ctrl.sv
// Single-clock read-modify-write sequencer for the inventory memory.
// One command every four cycles: accept, read, write, respond.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   S_IDLE  | cmd_ready high, waiting for a command
//   S_READ  | address driven, stock captured, update precomputed
//   S_WRITE | mem_set pulsed (unless query / rejected remove)
//   S_RESP  | rsp_valid strobe with resulting quantity and status
module inventory_ctrl
    import inv_pkg::*;
#(
    parameter int AW            = 8,
    parameter int DW            = 8,
    parameter int STRICT_REMOVE = 0
) (
    input  logic          clk,
    input  logic          rst,
    inventory_ctrl_if.slave bus
);

    ctrl_state_t   state;
    op_t           op_q;
    logic [DW-1:0] quant_q;
    logic [DW-1:0] stock_q;
    logic [DW-1:0] value_q;
    logic [AW-1:0] addr_q;
    logic          set_q;
    status_t       status_q;
    logic          rsp_valid_q;
    logic [DW-1:0] rsp_qty_q;
    status_t       rsp_status_q;
    logic          busy_q;

    logic [DW-1:0] alu_new;
    status_t       alu_status;
    logic          alu_wen;

    // Update is computed from the live read data so the write strobe can be registered.
    inv_alu #(
        .DW            (DW),
        .STRICT_REMOVE (STRICT_REMOVE)
    ) u_alu (
        .stock    (bus.mem_out),
        .quant    (quant_q),
        .op       (op_q),
        .new_qty  (alu_new),
        .status   (alu_status),
        .write_en (alu_wen)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            op_q         <= OP_ADD;
            quant_q      <= '0;
            stock_q      <= '0;
            value_q      <= '0;
            addr_q       <= '0;
            set_q        <= 1'b0;
            status_q     <= ST_OK;
            rsp_valid_q  <= 1'b0;
            rsp_qty_q    <= '0;
            rsp_status_q <= ST_OK;
            busy_q       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    rsp_valid_q <= 1'b0;
                    if (bus.cmd_valid) begin
                        op_q    <= bus.cmd_op;
                        addr_q  <= bus.cmd_code;
                        quant_q <= bus.cmd_quant;
                        busy_q  <= 1'b1;
                        state   <= S_READ;
                    end
                end
                S_READ: begin
                    stock_q  <= bus.mem_out;
                    value_q  <= alu_new;
                    status_q <= alu_status;
                    set_q    <= alu_wen;
                    state    <= S_WRITE;
                end
                S_WRITE: begin
                    set_q        <= 1'b0;
                    rsp_valid_q  <= 1'b1;
                    rsp_qty_q    <= set_q ? value_q : stock_q;
                    rsp_status_q <= status_q;
                    state        <= S_RESP;
                end
                S_RESP: begin
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    addr_q      <= '0;
                    state       <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Reset masks ready and the write strobe in the same cycle it is asserted.
    assign bus.cmd_ready   = (state == S_IDLE) && !rst;
    assign bus.mem_set     = set_q && !rst;
    assign bus.mem_address = addr_q;
    assign bus.mem_value   = value_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_qty     = rsp_qty_q;
    assign bus.rsp_status  = rsp_status_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_inventory_ctrl.sv
// Bench for inventory_ctrl: lenient and strict variants driven in lockstep,
// each with its own behavioural memory and an arithmetic reference model.
module tb_inventory_ctrl;
    import inv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    op_t         cmd_op = OP_ADD;
    logic [7:0]  cmd_code = '0;
    logic [7:0]  cmd_quant = '0;
    logic        mem_init = 1'b0;
    logic        pre_en = 1'b0;
    logic [7:0]  pre_addr = '0;
    logic [7:0]  pre_val = '0;

    logic [7:0]  mem [2][256];
    int          ref_q [2][256];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    inventory_ctrl_if #(.AW(8), .DW(8)) b0 ();
    inventory_ctrl_if #(.AW(8), .DW(8)) b1 ();

    inventory_ctrl #(.AW(8), .DW(8), .STRICT_REMOVE(0)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
    inventory_ctrl #(.AW(8), .DW(8), .STRICT_REMOVE(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

    assign b0.cmd_valid = cmd_valid;
    assign b0.cmd_op    = cmd_op;
    assign b0.cmd_code  = cmd_code;
    assign b0.cmd_quant = cmd_quant;
    assign b1.cmd_valid = cmd_valid;
    assign b1.cmd_op    = cmd_op;
    assign b1.cmd_code  = cmd_code;
    assign b1.cmd_quant = cmd_quant;
    assign b0.mem_out   = mem[0][b0.mem_address];
    assign b1.mem_out   = mem[1][b1.mem_address];

    logic       ms [2];
    logic       cr [2];
    logic       rv [2];
    logic       bz [2];
    logic [7:0] ma [2];
    logic [7:0] mv [2];
    logic [7:0] rq [2];
    logic [1:0] rs [2];
    assign ms[0] = b0.mem_set;     assign ms[1] = b1.mem_set;
    assign cr[0] = b0.cmd_ready;   assign cr[1] = b1.cmd_ready;
    assign rv[0] = b0.rsp_valid;   assign rv[1] = b1.rsp_valid;
    assign bz[0] = b0.busy;        assign bz[1] = b1.busy;
    assign ma[0] = b0.mem_address; assign ma[1] = b1.mem_address;
    assign mv[0] = b0.mem_value;   assign mv[1] = b1.mem_value;
    assign rq[0] = b0.rsp_qty;     assign rq[1] = b1.rsp_qty;
    assign rs[0] = b0.rsp_status;  assign rs[1] = b1.rsp_status;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_init) begin
                for (int i = 0; i < 256; i++) mem[k][i] <= 8'd0;
            end else if (ms[k]) begin
                mem[k][ma[k]] <= mv[k];
            end else if (pre_en) begin
                mem[k][pre_addr] <= pre_val;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Expected outcome straight from the inventory rules.
    function automatic void model(input int strict, input int op, input int stock, input int quant,
                                  output int q, output int st, output int w);
        q = stock; st = 0; w = 0;
        case (op)
            0: begin
                w = 1;
                if (stock + quant > 255) begin q = 255; st = 1; end
                else q = stock + quant;
            end
            1: begin
                if (quant <= stock) begin q = stock - quant; w = 1; end
                else begin
                    st = 2;
                    if (strict == 0) begin q = 0; w = 1; end
                end
            end
            3: begin q = 0; w = 1; end
            default: ;
        endcase
    endfunction

    task automatic preload(input int code, input int val);
        pre_en = 1'b1; pre_addr = code[7:0]; pre_val = val[7:0];
        @(negedge clk);
        pre_en = 1'b0;
        ref_q[0][code] = val;
        ref_q[1][code] = val;
    endtask

    task automatic run_cmd(input int op, input int code, input int quant,
                           input int q0, input int s0, input int w0,
                           input int q1, input int s1, input int w1);
        int eq[2]; int es[2]; int ew[2]; int w;
        eq[0] = q0; es[0] = s0; ew[0] = w0;
        eq[1] = q1; es[1] = s1; ew[1] = w1;
        cmd_valid = 1'b1; cmd_op = op_t'(op[1:0]); cmd_code = code[7:0]; cmd_quant = quant[7:0];
        w = 0;
        while (!cr[0] && w < 16) begin @(negedge clk); w++; end
        chk("accept_timeout", (w < 16) ? 1 : 0, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("read_ready[%0d]", k), cr[k], 0);
            chk($sformatf("read_set[%0d]", k), ms[k], 0);
            chk($sformatf("read_addr[%0d]", k), ma[k], code);
            chk($sformatf("read_busy[%0d]", k), bz[k], 1);
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("write_set[%0d] op%0d", k, op), ms[k], ew[k]);
            if (ew[k] != 0) chk($sformatf("write_value[%0d]", k), mv[k], eq[k]);
            chk($sformatf("write_addr[%0d]", k), ma[k], code);
            chk($sformatf("write_rsp_early[%0d]", k), rv[k], 0);
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rsp_valid[%0d]", k), rv[k], 1);
            chk($sformatf("rsp_qty[%0d] op%0d", k, op), rq[k], eq[k]);
            chk($sformatf("rsp_status[%0d] op%0d", k, op), rs[k], es[k]);
            chk($sformatf("mem_content[%0d]", k), mem[k][code], eq[k]);
            chk($sformatf("resp_ready[%0d]", k), cr[k], 0);
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("idle_rsp[%0d]", k), rv[k], 0);
            chk($sformatf("idle_ready[%0d]", k), cr[k], 1);
            chk($sformatf("idle_addr[%0d]", k), ma[k], 0);
            chk($sformatf("idle_busy[%0d]", k), bz[k], 0);
        end
        ref_q[0][code] = eq[0];
        ref_q[1][code] = eq[1];
    endtask

    task automatic run_model_cmd(input int op, input int code, input int quant);
        int q[2]; int s[2]; int w[2];
        for (int k = 0; k < 2; k++) model(k, op, ref_q[k][code], quant, q[k], s[k], w[k]);
        run_cmd(op, code, quant, q[0], s[0], w[0], q[1], s[1], w[1]);
    endtask

    typedef struct {
        int op; int code; int quant; int pre;
        int q0; int s0; int w0;
        int q1; int s1; int w1;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int bop [3]; int bquant [3]; int bexp [3]; int acc [3];
        int t; int nacc; int nrsp; int dq; int ds; int dw;

        tbl[0] = '{0, 5, 10,  -1,  10, 0, 1,  10, 0, 1};
        tbl[1] = '{0, 5, 10, 250, 255, 1, 1, 255, 1, 1};
        tbl[2] = '{0, 5,  5, 250, 255, 0, 1, 255, 0, 1};
        tbl[3] = '{1, 7, 20,  20,   0, 0, 1,   0, 0, 1};
        tbl[4] = '{1, 7, 30,  20,   0, 2, 1,  20, 2, 0};
        tbl[5] = '{2, 5,  0,  77,  77, 0, 0,  77, 0, 0};
        tbl[6] = '{3, 5,  9,  77,   0, 0, 1,   0, 0, 1};
        tbl[7] = '{0, 9,  0, 255, 255, 0, 1, 255, 0, 1};
        tbl[8] = '{1, 3,  1,   0,   0, 2, 1,   0, 2, 0};

        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 256; i++) ref_q[k][i] = 0;

        mem_init = 1'b1;
        repeat (3) @(negedge clk);
        mem_init = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("reset_ready[%0d]", k), cr[k], 0);
            chk($sformatf("reset_set[%0d]", k), ms[k], 0);
            chk($sformatf("reset_rsp[%0d]", k), rv[k], 0);
            chk($sformatf("reset_busy[%0d]", k), bz[k], 0);
            chk($sformatf("reset_addr[%0d]", k), ma[k], 0);
            chk($sformatf("reset_value[%0d]", k), mv[k], 0);
            chk($sformatf("reset_qty[%0d]", k), rq[k], 0);
            chk($sformatf("reset_status[%0d]", k), rs[k], 0);
        end
        rst = 1'b0;
        #1;
        chk("first_cycle_ready", cr[0], 1);

        for (int i = 0; i < 9; i++) begin
            if (tbl[i].pre >= 0) preload(tbl[i].code, tbl[i].pre);
            run_cmd(tbl[i].op, tbl[i].code, tbl[i].quant,
                    tbl[i].q0, tbl[i].s0, tbl[i].w0, tbl[i].q1, tbl[i].s1, tbl[i].w1);
        end

        // Back-to-back: cmd_valid held high across three commands.
        preload(1, 0);
        bop[0] = 0; bquant[0] = 3;
        bop[1] = 0; bquant[1] = 4;
        bop[2] = 2; bquant[2] = 0;
        for (int i = 0; i < 3; i++) begin
            model(0, bop[i], ref_q[0][1], bquant[i], dq, ds, dw);
            bexp[i] = dq;
            ref_q[0][1] = dq;
            ref_q[1][1] = dq;
        end
        for (int i = 0; i < 3; i++) acc[i] = -100;
        cmd_valid = 1'b1; cmd_op = op_t'(bop[0][1:0]); cmd_code = 8'd1; cmd_quant = bquant[0][7:0];
        t = 0; nacc = 0; nrsp = 0;
        while (nrsp < 3 && t < 40) begin
            if (rv[0]) begin
                for (int k = 0; k < 2; k++)
                    chk($sformatf("b2b_qty%0d[%0d]", nrsp, k), rq[k], bexp[nrsp]);
                nrsp++;
            end
            for (int k = 0; k < 2; k++)
                chk($sformatf("b2b_ready_vs_busy[%0d]", k), cr[k], !bz[k]);
            if (cr[0] && nacc < 3) begin acc[nacc] = t; nacc++; end
            @(negedge clk);
            t++;
            if (nacc < 3) begin
                cmd_op = op_t'(bop[nacc][1:0]); cmd_quant = bquant[nacc][7:0];
            end else begin
                cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        chk("b2b_responses", nrsp, 3);
        chk("b2b_gap01", acc[1] - acc[0], 4);
        chk("b2b_gap12", acc[2] - acc[1], 4);

        // Reset landing in the WRITE cycle of an ADD.
        preload(5, 40);
        cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_code = 8'd5; cmd_quant = 8'd10;
        chk("abort_accept_ready", cr[0], 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("abort_write_pending", ms[0], 1);
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("abort_set_gated[%0d]", k), ms[k], 0);
            chk($sformatf("abort_ready_gated[%0d]", k), cr[k], 0);
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("abort_rsp[%0d]", k), rv[k], 0);
            chk($sformatf("abort_busy[%0d]", k), bz[k], 0);
            chk($sformatf("abort_addr[%0d]", k), ma[k], 0);
            chk($sformatf("abort_mem[%0d]", k), mem[k][5], 40);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("abort_no_late_rsp[%0d]", k), rv[k], 0);
            chk($sformatf("abort_mem_after[%0d]", k), mem[k][5], 40);
        end
        run_model_cmd(0, 5, 1);

        // Randomized traffic on a small code range so entries get revisited.
        for (int n = 0; n < 150; n++) begin
            int op; int code; int quant;
            op    = int'($urandom_range(0, 3));
            code  = int'($urandom_range(0, 7));
            quant = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                                : int'($urandom_range(0, 40));
            run_model_cmd(op, code, quant);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
